// File: rtl/vga_timing_patgen_if.sv
// Video output bundle of the VGA timing / test-pattern generator.
// The master side (the generator) drives sync, enable, colour and strobes and takes sel.
interface vga_timing_patgen_if #(
    parameter int unsigned COLOR_W = 2
);
    logic               sel;
    logic               hs;
    logic               vs;
    logic               de;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
    logic               frame_start;
    logic [2:0]         pattern;

    modport master (
        input  sel,
        output hs, vs, de, r, g, b, frame_start, pattern
    );

    modport slave (
        output sel,
        input  hs, vs, de, r, g, b, frame_start, pattern
    );
endinterface

// File: rtl/vga_timing_patgen.sv
// VGA timing and five-pattern test generator with registered, mutually aligned outputs.
// Optional macro VGA_PATTERN_FRAME_LOCK_EN defers pattern changes to the next frame start.
module vga_timing_patgen #(
    parameter int unsigned COLOR_W  = 2,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic                clock,
    input  logic                reset,
    vga_timing_patgen_if.master vid
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned FS      = (1 << COLOR_W) - 1;
    localparam int unsigned BAND_W  = H_ACTIVE >> COLOR_W;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned SEG_W   = $clog2(H_ACTIVE + 1);
    localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END  = HS_BEG + H_SYNC;
    localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END  = VS_BEG + V_SYNC;

    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic               h_wrap_c;
    logic               v_wrap_c;
    logic [SEG_W-1:0]   band_seg;
    logic [SEG_W-1:0]   bar_seg;
    logic [COLOR_W-1:0] band_idx;
    logic [3:0]         bar_idx;
    logic [2:0]         sel_sync;
    logic               sel_edge_c;
    logic [2:0]         pattern_q;
    logic               active_c;
    logic               hs_c;
    logic               vs_c;
    logic               chk_c;
    logic [COLOR_W-1:0] r_c;
    logic [COLOR_W-1:0] g_c;
    logic [COLOR_W-1:0] b_c;

    assign h_wrap_c = (h_cnt == H_W'(H_TOTAL - 1));
    assign v_wrap_c = (v_cnt == V_W'(V_TOTAL - 1));

    // Raster counters; v_cnt steps only when the line wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap_c) begin
            h_cnt <= '0;
            v_cnt <= v_wrap_c ? '0 : v_cnt + V_W'(1);
        end else begin
            h_cnt <= h_cnt + H_W'(1);
        end
    end

    // Band/bar segment counters track h_cnt and reload at every line start.
    always_ff @(posedge clock) begin
        if (reset || h_wrap_c) begin
            band_seg <= '0;
            band_idx <= '0;
            bar_seg  <= '0;
            bar_idx  <= '0;
        end else begin
            if (band_idx != COLOR_W'(FS)) begin
                if (band_seg == SEG_W'(BAND_W - 1)) begin
                    band_seg <= '0;
                    band_idx <= band_idx + COLOR_W'(1);
                end else begin
                    band_seg <= band_seg + SEG_W'(1);
                end
            end
            if (bar_idx != 4'd8) begin
                if (bar_seg == SEG_W'(BAR_W - 1)) begin
                    bar_seg <= '0;
                    bar_idx <= bar_idx + 4'd1;
                end else begin
                    bar_seg <= bar_seg + SEG_W'(1);
                end
            end
        end
    end

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_sync <= '0;
        end else begin
            sel_sync <= {sel_sync[1:0], vid.sel};
        end
    end

    assign sel_edge_c = sel_sync[1] & ~sel_sync[2];

    function automatic logic [2:0] pat_next(input logic [2:0] p);
        return (p == 3'd4) ? 3'd0 : p + 3'd1;
    endfunction

`ifdef VGA_PATTERN_FRAME_LOCK_EN
    logic pending;

    // Edges only arm a request; the pattern moves as the raster wraps to (0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            pending   <= 1'b0;
            pattern_q <= '0;
        end else if (h_wrap_c && v_wrap_c) begin
            if (pending || sel_edge_c) begin
                pattern_q <= pat_next(pattern_q);
            end
            pending <= 1'b0;
        end else if (sel_edge_c) begin
            pending <= 1'b1;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            pattern_q <= '0;
        end else if (sel_edge_c) begin
            pattern_q <= pat_next(pattern_q);
        end
    end
`endif

    // Pixel function of the current counters and pattern.
    always_comb begin
        active_c = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
        hs_c     = (h_cnt >= H_W'(HS_BEG)) && (h_cnt < H_W'(HS_END));
        vs_c     = (v_cnt >= V_W'(VS_BEG)) && (v_cnt < V_W'(VS_END));
        chk_c    = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];
        r_c      = '0;
        g_c      = '0;
        b_c      = '0;
        case (pattern_q)
            3'd0: begin
                r_c = band_idx;
                g_c = band_idx;
                b_c = band_idx;
            end
            3'd1: r_c = COLOR_W'(FS);
            3'd2: begin
                r_c = COLOR_W'(FS);
                g_c = COLOR_W'(FS);
                b_c = COLOR_W'(FS);
            end
            3'd3: begin
                if (bar_idx < 4'd8) begin
                    r_c = {COLOR_W{~bar_idx[1]}};
                    g_c = {COLOR_W{~bar_idx[2]}};
                    b_c = {COLOR_W{~bar_idx[0]}};
                end
            end
            3'd4: begin
                if (chk_c) begin
                    r_c = COLOR_W'(FS);
                    g_c = COLOR_W'(FS);
                    b_c = COLOR_W'(FS);
                end
            end
            default: ;
        endcase
        if (!active_c) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Output stage: every output reflects the counters of the previous clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            vid.hs          <= ~HS_POL;
            vid.vs          <= ~VS_POL;
            vid.de          <= 1'b0;
            vid.r           <= '0;
            vid.g           <= '0;
            vid.b           <= '0;
            vid.frame_start <= 1'b0;
            vid.pattern     <= '0;
        end else begin
            vid.hs          <= hs_c ? HS_POL : ~HS_POL;
            vid.vs          <= vs_c ? VS_POL : ~VS_POL;
            vid.de          <= active_c;
            vid.r           <= r_c;
            vid.g           <= g_c;
            vid.b           <= b_c;
            vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
            vid.pattern     <= pattern_q;
        end
    end
endmodule

// File: tb/tb_vga_timing_patgen.sv
// Self-checking bench for vga_timing_patgen using a reduced raster and an arithmetic pixel model.
// Honours VGA_PATTERN_FRAME_LOCK_EN to select which pattern-advance behaviour is expected.
module tb_vga_timing_patgen;
    localparam int HA = 50, HFP = 3, HSW = 5, HBP = 4;
    localparam int VA = 20, VFP = 2, VSW = 3, VBP = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int CHK = 3;
    localparam int FSV = 3;

    logic clock = 1'b0;
    logic reset;
    int unsigned n_edges;
    int tests;
    int fails;
    int exp_pat;
    logic [12:0] act_vec;

    vga_timing_patgen_if #(.COLOR_W(2)) vif();

    vga_timing_patgen #(
        .COLOR_W(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(CHK)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vid   (vif)
    );

    always #5 clock = ~clock;

    // Edges since reset release; after edge k the output shows raster pixel k-1.
    always @(posedge clock) begin
        if (reset) n_edges <= 0;
        else       n_edges <= n_edges + 1;
    end

    assign act_vec = {vif.hs, vif.vs, vif.de, vif.r, vif.g, vif.b, vif.frame_start, vif.pattern};

    function automatic int cur_pix();
        return (n_edges == 0) ? 0 : int'((n_edges - 1) % FRAME);
    endfunction

    // Expected output bundle for a raster position under a given pattern.
    function automatic logic [12:0] exp_vec(input int pix, input int pat);
        int h, v, k;
        logic hs, vs, de, fs;
        logic [1:0] r, g, b;
        logic [7:0] rmask, gmask, bmask;
        rmask = 8'h33; gmask = 8'h0F; bmask = 8'h55;
        h  = pix % HT;
        v  = pix / HT;
        de = (h < HA) && (v < VA);
        hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
        vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
        fs = (pix == 0);
        r = 2'd0; g = 2'd0; b = 2'd0;
        if (de) begin
            case (pat)
                0: begin
                    k = h / (HA >> 2);
                    if (k > FSV) k = FSV;
                    r = 2'(k); g = 2'(k); b = 2'(k);
                end
                1: r = 2'(FSV);
                2: begin r = 2'(FSV); g = 2'(FSV); b = 2'(FSV); end
                3: begin
                    k = h / (HA / 8);
                    if (k < 8) begin
                        r = rmask[k] ? 2'(FSV) : 2'd0;
                        g = gmask[k] ? 2'(FSV) : 2'd0;
                        b = bmask[k] ? 2'(FSV) : 2'd0;
                    end
                end
                4: if ((((h >> CHK) ^ (v >> CHK)) & 1) == 1) begin
                    r = 2'(FSV); g = 2'(FSV); b = 2'(FSV);
                end
                default: ;
            endcase
        end
        return {hs, vs, de, r, g, b, fs, 3'(pat)};
    endfunction

    task automatic run_to(input int target);
        int d;
        d = (target - cur_pix() + FRAME) % FRAME;
        repeat (d) @(negedge clock);
    endtask

    task automatic pulse_sel(input int width);
        vif.sel = 1'b1;
        repeat (width) @(negedge clock);
        vif.sel = 1'b0;
    endtask

    // Issues one sel pulse and waits until the new pattern is visible at the output.
    task automatic advance_pat(input int width);
`ifdef VGA_PATTERN_FRAME_LOCK_EN
        run_to(10 * HT);
        pulse_sel(width);
        run_to(0);
`else
        pulse_sel(width);
        repeat (8) @(negedge clock);
`endif
        exp_pat = (exp_pat + 1) % 5;
    endtask

    task automatic test_reset(input bit mid);
        if (mid) begin
            repeat ($urandom_range(5, 40)) @(negedge clock);
            if (exp_pat == 0) advance_pat(2);
            run_to(HT + 7 + int'($urandom_range(0, 20)));
            reset = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            tests++;
            if (act_vec !== 13'd0) begin
                fails++;
                $display("FAIL reset_hold cyc=%0d got=%h expected=%h", i, act_vec, 13'd0);
            end
        end
        reset = 1'b0;
        exp_pat = 0;
        @(negedge clock);
        tests++;
        if (act_vec !== exp_vec(0, 0) || vif.de !== 1'b1) begin
            fails++;
            $display("FAIL reset_release got=%h expected=%h", act_vec, exp_vec(0, 0));
        end
    endtask

    task automatic test_h_timing();
        int de_cnt, hs_cnt, hs_rise, de_rise1;
        logic prev_hs, prev_de;
        run_to(0);
        de_cnt = 0; hs_cnt = 0; hs_rise = -1; de_rise1 = -1;
        prev_hs = 1'b0; prev_de = 1'b1;
        for (int i = 0; i < 2 * HT; i++) begin
            tests++;
            if (act_vec !== exp_vec(i, exp_pat)) begin
                fails++;
                $display("FAIL h_pixel pix=%0d got=%h expected=%h", i, act_vec, exp_vec(i, exp_pat));
            end
            if (i < HT) begin
                if (vif.de) de_cnt++;
                if (vif.hs) hs_cnt++;
                if (vif.hs && !prev_hs && hs_rise < 0) hs_rise = i;
            end else if (vif.de && !prev_de && de_rise1 < 0) begin
                de_rise1 = i;
            end
            prev_hs = vif.hs;
            prev_de = vif.de;
            @(negedge clock);
        end
        tests++;
        if (de_cnt != 50) begin fails++; $display("FAIL de_width got=%0d expected=50", de_cnt); end
        tests++;
        if (hs_cnt != 5) begin fails++; $display("FAIL hs_width got=%0d expected=5", hs_cnt); end
        tests++;
        if (hs_rise != 53) begin fails++; $display("FAIL hs_rise got=%0d expected=53", hs_rise); end
        tests++;
        if (de_rise1 != 62) begin fails++; $display("FAIL line_period got=%0d expected=62", de_rise1); end
    endtask

    task automatic test_v_timing();
        int vs_cnt, vs_rise, fs_first, fs_second;
        logic prev_vs;
        run_to(0);
        vs_cnt = 0; vs_rise = -1; fs_first = -1; fs_second = -1; prev_vs = 1'b0;
        for (int i = 0; i < FRAME + HT; i++) begin
            tests++;
            if (act_vec !== exp_vec(i % FRAME, exp_pat)) begin
                fails++;
                $display("FAIL v_pixel pix=%0d got=%h expected=%h", i, act_vec, exp_vec(i % FRAME, exp_pat));
            end
            if (i < FRAME && vif.vs) vs_cnt++;
            if (vif.vs && !prev_vs && vs_rise < 0) vs_rise = i;
            if (vif.frame_start) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            prev_vs = vif.vs;
            @(negedge clock);
        end
        tests++;
        if (vs_rise != 22 * 62) begin fails++; $display("FAIL vs_rise got=%0d expected=%0d", vs_rise, 22 * 62); end
        tests++;
        if (vs_cnt != 3 * 62) begin fails++; $display("FAIL vs_width got=%0d expected=%0d", vs_cnt, 3 * 62); end
        tests++;
        if (fs_second - fs_first != 1798) begin
            fails++;
            $display("FAIL frame_period got=%0d expected=1798", fs_second - fs_first);
        end
    endtask

    task automatic test_patterns();
        logic [5:0] rgb;
        for (int p = 0; p < 5; p++) begin
            for (int n = 0; n < 5 && exp_pat != p; n++) advance_pat(int'($urandom_range(1, 3)));
            for (int s = 0; s < 40; s++) begin
                repeat ($urandom_range(1, 37)) @(negedge clock);
                tests++;
                if (act_vec !== exp_vec(cur_pix(), exp_pat)) begin
                    fails++;
                    $display("FAIL pattern%0d_pixel pix=%0d got=%h expected=%h",
                             p, cur_pix(), act_vec, exp_vec(cur_pix(), exp_pat));
                end
            end
            case (p)
                0: begin
                    run_to(11); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o00) begin fails++; $display("FAIL ramp_x11 got=%o expected=00", rgb); end
                    run_to(12); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o25) begin fails++; $display("FAIL ramp_x12 got=%o expected=25", rgb); end
                    run_to(24); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o52) begin fails++; $display("FAIL ramp_x24 got=%o expected=52", rgb); end
                    run_to(49); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o77) begin fails++; $display("FAIL ramp_x49 got=%o expected=77", rgb); end
                end
                3: begin
                    run_to(6); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'b111100) begin fails++; $display("FAIL bars_yellow got=%b expected=111100", rgb); end
                    run_to(49); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'b000000) begin fails++; $display("FAIL bars_remainder got=%b expected=000000", rgb); end
                end
                4: begin
                    run_to(8); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o77) begin fails++; $display("FAIL chk_8_0 got=%o expected=77", rgb); end
                    run_to(8 * HT + 8); rgb = {vif.r, vif.g, vif.b}; tests++;
                    if (rgb !== 6'o00) begin fails++; $display("FAIL chk_8_8 got=%o expected=00", rgb); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_blank_rgb();
        for (int n = 0; n < 5 && exp_pat != 2; n++) advance_pat(1);
        run_to((VA - 1) * HT);
        for (int i = 0; i < (VT - VA + 1) * HT; i++) begin
            tests++;
            if (!vif.de && {vif.r, vif.g, vif.b} !== 6'd0) begin
                fails++;
                $display("FAIL blank_rgb pix=%0d got=%o expected=00", cur_pix(), {vif.r, vif.g, vif.b});
            end else if (vif.de && {vif.r, vif.g, vif.b} !== 6'o77) begin
                fails++;
                $display("FAIL white_rgb pix=%0d got=%o expected=77", cur_pix(), {vif.r, vif.g, vif.b});
            end
            @(negedge clock);
        end
    endtask

    task automatic test_sel();
        int start, want;
        start = exp_pat;
        for (int i = 0; i < 5; i++) begin
            advance_pat((i == 0) ? 1 : int'($urandom_range(1, 4)));
            want = (start + i + 1) % 5;
            tests++;
            if (vif.pattern !== 3'(want)) begin
                fails++;
                $display("FAIL sel_step%0d got=%0d expected=%0d", i, vif.pattern, want);
            end
        end
        tests++;
        if (vif.pattern !== 3'(start)) begin
            fails++;
            $display("FAIL sel_wrap got=%0d expected=%0d", vif.pattern, start);
        end
    endtask

`ifdef VGA_PATTERN_FRAME_LOCK_EN
    task automatic test_frame_lock();
        int old, want;
        old = exp_pat;
        want = (old + 1) % 5;
        run_to(10 * HT);
        pulse_sel(1);
        repeat (20) @(negedge clock);
        pulse_sel(2);
        for (int i = 0; i < FRAME && cur_pix() != 0; i++) begin
            tests++;
            if (vif.pattern !== 3'(old)) begin
                fails++;
                $display("FAIL lock_hold pix=%0d got=%0d expected=%0d", cur_pix(), vif.pattern, old);
            end
            @(negedge clock);
        end
        tests++;
        if (vif.pattern !== 3'(want) || vif.frame_start !== 1'b1) begin
            fails++;
            $display("FAIL lock_update got=%0d/%b expected=%0d/1", vif.pattern, vif.frame_start, want);
        end
        run_to(1);
        run_to(0);
        tests++;
        if (vif.pattern !== 3'(want)) begin
            fails++;
            $display("FAIL lock_single_step got=%0d expected=%0d", vif.pattern, want);
        end
        exp_pat = want;
    endtask
`else
    task automatic test_back_to_back();
        int want;
        want = (exp_pat + 2) % 5;
        pulse_sel(1);
        repeat (3) @(negedge clock);
        pulse_sel(1);
        repeat (8) @(negedge clock);
        tests++;
        if (vif.pattern !== 3'(want)) begin
            fails++;
            $display("FAIL back_to_back got=%0d expected=%0d", vif.pattern, want);
        end
        exp_pat = want;
        for (int s = 0; s < 20; s++) begin
            repeat ($urandom_range(1, 29)) @(negedge clock);
            tests++;
            if (act_vec !== exp_vec(cur_pix(), exp_pat)) begin
                fails++;
                $display("FAIL b2b_pixel pix=%0d got=%h expected=%h",
                         cur_pix(), act_vec, exp_vec(cur_pix(), exp_pat));
            end
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        vif.sel = 1'b0;
        tests   = 0;
        fails   = 0;
        exp_pat = 0;
        repeat (2) @(negedge clock);
        test_reset(1'b0);
        test_h_timing();
        test_v_timing();
        test_patterns();
        test_blank_rgb();
        test_sel();
`ifdef VGA_PATTERN_FRAME_LOCK_EN
        test_frame_lock();
`else
        test_back_to_back();
`endif
        test_reset(1'b1);
        test_h_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
